// File: rtl/mem_stg_if.sv
// rtl/mem_stg_if.sv - data-memory req/ack port between the memory stage and memory
interface mem_stg_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stg.sv
// rtl/mem_stg.sv - memory pipeline stage: EXE/MEM register, req/ack load/store, MEM/WB register
module mem_stg #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ST_value,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        WB_EN,
  input  logic [4:0]  dest,
  output logic [31:0] ALU_res_MEM,
  output logic        stall,
  mem_stg_if.master   mem,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mem_data,
  output logic        wb_mem_r_en,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        m_valid_q, m_valid_d;
  logic [31:0] m_alu_q, m_alu_d;
  logic [31:0] m_st_q, m_st_d;
  logic        m_r_en_q, m_r_en_d;
  logic        m_w_en_q, m_w_en_d;
  logic        m_wb_en_q, m_wb_en_d;
  logic [4:0]  m_dest_q, m_dest_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_alu_res_q, wb_alu_res_d;
  logic [31:0] wb_mem_data_q, wb_mem_data_d;
  logic        wb_mem_r_en_q, wb_mem_r_en_d;
  logic        err_misalign_q, err_misalign_d;
  logic        err_timeout_q, err_timeout_d;

  logic        mem_op;
  logic        aligned;
  logic        access;
  logic        timeout;
  logic        done;
  logic        stall_c;
  logic        drop;

  // The access is issued combinationally from the held EXE/MEM contents, so a
  // same-cycle ack completes with zero wait states.
  always_comb begin
    mem_op  = m_valid_q & (m_r_en_q | m_w_en_q);
    aligned = (m_alu_q[1:0] == 2'b00);
    access  = mem_op & aligned;
    timeout = (state_q == ACCESS) & ~mem.mem_ack & (cnt_q == TO_LIMIT);
    done    = access & mem.mem_ack;
    stall_c = access & ~mem.mem_ack & ~timeout;
    drop    = (mem_op & ~aligned) | timeout;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access && !mem.mem_ack) begin
          state_d = ACCESS;
          cnt_d   = 8'd1;
        end
      end
      ACCESS: begin
        if (!access || mem.mem_ack || timeout) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_alu_d   = m_alu_q;
    m_st_d    = m_st_q;
    m_r_en_d  = m_r_en_q;
    m_w_en_d  = m_w_en_q;
    m_wb_en_d = m_wb_en_q;
    m_dest_d  = m_dest_q;
    if (!stall_c) begin
      m_valid_d = ex_valid;
      m_alu_d   = ALUResult;
      m_st_d    = ST_value;
      m_r_en_d  = MEM_R_EN;
      m_w_en_d  = MEM_W_EN;
      m_wb_en_d = WB_EN;
      m_dest_d  = dest;
    end
  end

  // Stalled cycles and dropped accesses both leave MEM/WB as a bubble; the
  // payload fields keep their last values since nothing consumes them then.
  always_comb begin
    wb_valid_d    = wb_valid_q;
    wb_en_d       = wb_en_q;
    wb_dest_d     = wb_dest_q;
    wb_alu_res_d  = wb_alu_res_q;
    wb_mem_r_en_d = wb_mem_r_en_q;
    wb_mem_data_d = wb_mem_data_q;
    if (stall_c || drop) begin
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
    end else begin
      wb_valid_d    = m_valid_q;
      wb_en_d       = m_wb_en_q & m_valid_q;
      wb_dest_d     = m_dest_q;
      wb_alu_res_d  = m_alu_q;
      wb_mem_r_en_d = m_r_en_q;
    end
    if (done && !m_w_en_q) begin
      wb_mem_data_d = mem.mem_rdata;
    end
    err_misalign_d = mem_op & ~aligned;
    err_timeout_d  = timeout;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      m_valid_q      <= 1'b0;
      m_alu_q        <= 32'd0;
      m_st_q         <= 32'd0;
      m_r_en_q       <= 1'b0;
      m_w_en_q       <= 1'b0;
      m_wb_en_q      <= 1'b0;
      m_dest_q       <= 5'd0;
      wb_valid_q     <= 1'b0;
      wb_en_q        <= 1'b0;
      wb_dest_q      <= 5'd0;
      wb_alu_res_q   <= 32'd0;
      wb_mem_data_q  <= 32'd0;
      wb_mem_r_en_q  <= 1'b0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      m_valid_q      <= m_valid_d;
      m_alu_q        <= m_alu_d;
      m_st_q         <= m_st_d;
      m_r_en_q       <= m_r_en_d;
      m_w_en_q       <= m_w_en_d;
      m_wb_en_q      <= m_wb_en_d;
      m_dest_q       <= m_dest_d;
      wb_valid_q     <= wb_valid_d;
      wb_en_q        <= wb_en_d;
      wb_dest_q      <= wb_dest_d;
      wb_alu_res_q   <= wb_alu_res_d;
      wb_mem_data_q  <= wb_mem_data_d;
      wb_mem_r_en_q  <= wb_mem_r_en_d;
      err_misalign_q <= err_misalign_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  // Reset clears m_valid_q, which alone is enough to hold mem_req low.
  assign mem.mem_req   = access;
  assign mem.mem_we    = access & m_w_en_q;
  assign mem.mem_addr  = m_alu_q[ADDR_W+1:2];
  assign mem.mem_wdata = m_st_q;

  assign ALU_res_MEM  = m_alu_q;
  assign stall        = stall_c;
  assign wb_valid     = wb_valid_q;
  assign wb_en        = wb_en_q;
  assign wb_dest      = wb_dest_q;
  assign wb_alu_res   = wb_alu_res_q;
  assign wb_mem_data  = wb_mem_data_q;
  assign wb_mem_r_en  = wb_mem_r_en_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;

endmodule
